// File: rtl/ara_perf_pkg.sv
// Shared constants and types for the Ara/CVA6 performance counter APB block.
package ara_perf_pkg;

  // Register byte offsets (only paddr[7:0] is decoded)
  localparam logic [7:0] CtrlOff    = 8'h00;
  localparam logic [7:0] StatusOff  = 8'h04;
  localparam logic [7:0] CntBaseOff = 8'h08;

  // Counter slot assignment inside cnt_i
  localparam int unsigned RuntimeIdx = 0;
  localparam int unsigned DcacheIdx  = 1;
  localparam int unsigned IcacheIdx  = 2;
  localparam int unsigned SbFullIdx  = 3;

  typedef logic [63:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } apb_state_e;

  // Offset of the last valid register (CNT<num_cnt-1>_HI)
  function automatic logic [7:0] last_cnt_off(input int unsigned num_cnt);
    return 8'(32'd12 + 32'd8 * (num_cnt - 32'd1));
  endfunction

endpackage

// File: rtl/ara_perf_apb_fsm.sv
// APB3 responder state machine: one wait state per transfer, address decode and
// error classification. Register storage lives in the parent.
module ara_perf_apb_fsm
  import ara_perf_pkg::*;
#(
  parameter int unsigned NumCnt = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       psel_i,
  input  logic       penable_i,
  input  logic       pwrite_i,
  input  logic [7:0] offset_i,
  output logic       access_o,
  output logic       rd_en_o,
  output logic       wr_en_o,
  output logic       err_o,
  output logic       pready_o,
  output logic       pslverr_o
);

  localparam logic [7:0] LastOff = last_cnt_off(NumCnt);

  apb_state_e state_q, state_d;
  logic       pslverr_q;
  logic       bad_access;

  // Faulty transfers: unaligned, past the last counter, or writes to read-only counters
  assign bad_access = (offset_i[1:0] != 2'b00) || (offset_i > LastOff) ||
                      (pwrite_i && (offset_i >= CntBaseOff));

  // Next-state logic; the access strobe fires only in a valid ACCESS cycle
  always_comb begin
    state_d  = state_q;
    access_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel_i && !penable_i) state_d = StAccess;
      end
      StAccess: begin
        if (!psel_i) begin
          state_d = StIdle;
        end else if (penable_i) begin
          access_o = 1'b1;
          state_d  = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign err_o   = access_o && bad_access;
  assign rd_en_o = access_o && !bad_access && !pwrite_i;
  assign wr_en_o = access_o && !bad_access && pwrite_i;

  // State and error response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pslverr_q <= err_o;
    end
  end

  // Decoded from state so an async reset drops pready immediately
  assign pready_o  = (state_q == StResp);
  assign pslverr_o = pslverr_q;

endmodule

// File: rtl/ara_perf_cnt_apb.sv
// Performance counter snapshot block: captures NumCnt 64-bit counters on a pulse
// and exposes them over APB as LO/HI pairs with an atomic HI shadow.
module ara_perf_cnt_apb
  import ara_perf_pkg::*;
#(
  parameter int unsigned NumCnt    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter logic        EnRstVal  = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [31:0]            pwdata_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  input  logic                   snap_valid_i,
  input  logic [64*NumCnt-1:0]   cnt_i,
  output logic                   cnt_en_o
);

  localparam int unsigned IdxW = (NumCnt > 1) ? $clog2(NumCnt) : 1;

  logic [7:0]      offset;
  logic            access, rd_en, wr_en, err;
  logic [IdxW-1:0] cnt_idx;
  logic            is_hi;
  logic [31:0]     rdata;

  logic        cnt_en_q, cnt_en_d;
  logic        snap_ready_q, snap_ready_d;
  logic        overrun_q, overrun_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] prdata_q, prdata_d;
  cnt_t        snap_q [NumCnt];

  logic unused_bits;
  assign unused_bits = ^{paddr_i[AddrWidth-1:8], pwdata_i[31:2]};

  assign offset  = paddr_i[7:0];
  // Counter pair index and LO/HI select within the counter window
  assign cnt_idx = IdxW'(offset[7:3] - 5'd1);
  assign is_hi   = offset[2];

  ara_perf_apb_fsm #(
    .NumCnt (NumCnt)
  ) u_fsm (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .offset_i  (offset),
    .access_o  (access),
    .rd_en_o   (rd_en),
    .wr_en_o   (wr_en),
    .err_o     (err),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o)
  );

  // Read mux; only consulted for decoded, error-free reads
  always_comb begin
    rdata = '0;
    if (offset == CtrlOff) begin
      rdata[0] = cnt_en_q;
    end else if (offset == StatusOff) begin
      rdata[1:0] = {overrun_q, snap_ready_q};
    end else if (is_hi) begin
      rdata = shadow_q;
    end else begin
      rdata = snap_q[cnt_idx][31:0];
    end
  end

  // Register next-state: CTRL, W1C status (capture set wins), shadow, read data
  always_comb begin
    cnt_en_d     = cnt_en_q;
    snap_ready_d = snap_ready_q;
    overrun_d    = overrun_q;
    shadow_d     = shadow_q;
    prdata_d     = prdata_q;

    if (wr_en && (offset == CtrlOff)) cnt_en_d = pwdata_i[0];
    if (wr_en && (offset == StatusOff)) begin
      if (pwdata_i[0]) snap_ready_d = 1'b0;
      if (pwdata_i[1]) overrun_d    = 1'b0;
    end
    if (snap_valid_i) begin
      overrun_d    = overrun_d | snap_ready_q;
      snap_ready_d = 1'b1;
    end

    // LO read latches the matching HI half from the pre-capture snapshot
    if (rd_en && (offset >= CntBaseOff) && !is_hi) shadow_d = snap_q[cnt_idx][63:32];

    if (rd_en) begin
      prdata_d = rdata;
    end else if (access) begin
      prdata_d = '0;
    end
  end

  // Control, status and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_en_q     <= EnRstVal;
      snap_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      shadow_q     <= '0;
      prdata_q     <= '0;
    end else begin
      cnt_en_q     <= cnt_en_d;
      snap_ready_q <= snap_ready_d;
      overrun_q    <= overrun_d;
      shadow_q     <= shadow_d;
      prdata_q     <= prdata_d;
    end
  end

  // Snapshot capture of all counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCnt; i++) snap_q[i] <= '0;
    end else if (snap_valid_i) begin
      for (int i = 0; i < NumCnt; i++) snap_q[i] <= cnt_i[64*i +: 64];
    end
  end

  assign prdata_o = prdata_q;
  assign cnt_en_o = cnt_en_q;

endmodule

// File: tb/tb_ara_perf_cnt_apb.sv
// Self-checking bench: directed scenarios plus randomized APB traffic and snapshot
// pulses compared against a register-level reference model.
module tb_ara_perf_cnt_apb;

  localparam int unsigned NumCnt = 4;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 psel_i, penable_i, pwrite_i;
  logic [31:0]          paddr_i, pwdata_i;
  logic [31:0]          prdata_o;
  logic                 pready_o, pslverr_o;
  logic                 snap_valid_i;
  logic [64*NumCnt-1:0] cnt_i;
  logic                 cnt_en_o;

  logic [63:0] cnt_vals [NumCnt];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_en, m_ready, m_ovr;
  logic [63:0] m_snap [NumCnt];
  logic [31:0] m_shadow;

  ara_perf_cnt_apb #(
    .NumCnt    (NumCnt),
    .AddrWidth (32),
    .EnRstVal  (1'b0)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .psel_i       (psel_i),
    .penable_i    (penable_i),
    .pwrite_i     (pwrite_i),
    .paddr_i      (paddr_i),
    .pwdata_i     (pwdata_i),
    .prdata_o     (prdata_o),
    .pready_o     (pready_o),
    .pslverr_o    (pslverr_o),
    .snap_valid_i (snap_valid_i),
    .cnt_i        (cnt_i),
    .cnt_en_o     (cnt_en_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    cnt_i = '0;
    for (int i = 0; i < NumCnt; i++) cnt_i[64*i +: 64] = cnt_vals[i];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en     = 1'b0;
    m_ready  = 1'b0;
    m_ovr    = 1'b0;
    m_shadow = '0;
    for (int i = 0; i < NumCnt; i++) m_snap[i] = '0;
  endtask

  task automatic model_capture(input bit ready_before);
    if (ready_before) m_ovr = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < NumCnt; i++) m_snap[i] = cnt_vals[i];
  endtask

  // One transfer at register level; a coincident capture sees the pre-transfer status
  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit snap, output logic [31:0] rd, output bit err);
    int off;
    int last;
    int idx;
    bit ready_before;
    off          = int'(addr[7:0]);
    last         = 12 + 8 * (NumCnt - 1);
    ready_before = m_ready;
    err          = (off % 4 != 0) || (off > last) || (wr && off >= 8);
    rd           = '0;
    if (!err) begin
      if (wr) begin
        if (off == 0) m_en = wdata[0];
        if (off == 4) begin
          if (wdata[0]) m_ready = 1'b0;
          if (wdata[1]) m_ovr = 1'b0;
        end
      end else if (off == 0) begin
        rd = {31'b0, m_en};
      end else if (off == 4) begin
        rd = {30'b0, m_ovr, m_ready};
      end else begin
        idx = (off - 8) / 8;
        if ((off - 8) % 8 == 0) begin
          rd       = m_snap[idx][31:0];
          m_shadow = m_snap[idx][63:32];
        end else begin
          rd = m_shadow;
        end
      end
    end
    if (snap) model_capture(ready_before);
  endtask

  // Drives one APB transfer; optional capture pulse coincides with the ACCESS cycle
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit snap, output logic [31:0] rdata, output bit err,
                     output bit en_at_resp);
    int n;
    @(posedge clk_i); #1;
    psel_i    = 1'b1;
    penable_i = 1'b0;
    pwrite_i  = wr;
    paddr_i   = addr;
    pwdata_i  = wdata;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    if (snap) snap_valid_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      snap_valid_i = 1'b0;
      n++;
    end while (!pready_o && n < 8);
    check_eq("pready_latency", n, 1);
    rdata      = prdata_o;
    err        = pslverr_o;
    en_at_resp = cnt_en_o;
    @(posedge clk_i); #1;
    check_eq("pready_one_cycle", pready_o, 1'b0);
    psel_i    = 1'b0;
    penable_i = 1'b0;
    pwrite_i  = 1'b0;
  endtask

  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit snap, output logic [31:0] rd, output bit err);
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          en;
    apb(wr, addr, wdata, snap, rd, err, en);
    model_xfer(wr, addr, wdata, snap, exp_rd, exp_err);
    check_eq("prdata", rd, exp_rd);
    check_eq("pslverr", err, exp_err);
    check_eq("cnt_en", en, m_en);
  endtask

  task automatic pulse_snap();
    @(posedge clk_i); #1;
    snap_valid_i = 1'b1;
    @(posedge clk_i); #1;
    snap_valid_i = 1'b0;
    model_capture(m_ready);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    bit          err;
    bit          snap;
    bit          en;
    int          op;

    rst_ni       = 1'b0;
    psel_i       = 1'b0;
    penable_i    = 1'b0;
    pwrite_i     = 1'b0;
    paddr_i      = '0;
    pwdata_i     = '0;
    snap_valid_i = 1'b0;
    for (int i = 0; i < NumCnt; i++) cnt_vals[i] = '0;
    model_reset();

    #1;
    check_eq("rst_pready", pready_o, 1'b0);
    check_eq("rst_pslverr", pslverr_o, 1'b0);
    check_eq("rst_prdata", prdata_o, 32'h0);
    check_eq("rst_cnt_en", cnt_en_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset readback
    do_xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err);
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    do_xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err);
    check_eq("cnt0_lo_reset", rd, 32'h0);

    // CTRL enable set and clear
    do_xfer(1'b1, 32'h00, 32'h1, 1'b0, rd, err);
    check_eq("cnt_en_set", cnt_en_o, 1'b1);
    do_xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err);
    check_eq("ctrl_read_1", rd, 32'h1);
    do_xfer(1'b1, 32'h00, 32'hFFFF_FFFE, 1'b0, rd, err);
    do_xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err);
    check_eq("ctrl_read_0", rd, 32'h0);

    // Snapshot and atomic HI readout
    cnt_vals[0] = 64'h0000_0012_3456_789A;
    pulse_snap();
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    check_eq("status_ready", rd, 32'h1);
    do_xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, err);
    check_eq("cnt0_lo", rd, 32'h3456_789A);
    cnt_vals[0] = 64'h0000_0099_0000_0000;
    pulse_snap();
    do_xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, err);
    check_eq("cnt0_hi_shadow", rd, 32'h12);

    // Overrun, W1C racing a capture, then a plain clear
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    check_eq("status_overrun", rd, 32'h3);
    do_xfer(1'b1, 32'h04, 32'h3, 1'b1, rd, err);
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    check_eq("status_set_wins", rd, 32'h3);
    do_xfer(1'b1, 32'h04, 32'h3, 1'b0, rd, err);
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    check_eq("status_cleared", rd, 32'h0);

    // Error responses
    do_xfer(1'b0, 32'h06, 32'h0, 1'b0, rd, err);
    check_eq("err_unaligned", err, 1'b1);
    do_xfer(1'b0, 32'h40, 32'h0, 1'b0, rd, err);
    check_eq("err_range", err, 1'b1);
    do_xfer(1'b1, 32'h10, 32'h5, 1'b0, rd, err);
    check_eq("err_ro_write", err, 1'b1);
    check_eq("err_prdata", rd, 32'h0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 9));
      if (op < 2) begin
        for (int i = 0; i < NumCnt; i++) cnt_vals[i] = {$urandom(), $urandom()};
        pulse_snap();
      end else begin
        case ($urandom_range(0, 3))
          0:       addr = $urandom();
          1:       addr = {$urandom_range(0, 255), 8'($urandom_range(0, 47))};
          default: addr = 32'($urandom_range(0, 11)) * 32'd4;
        endcase
        snap = ($urandom_range(0, 5) == 0);
        if (snap) begin
          for (int i = 0; i < NumCnt; i++) cnt_vals[i] = {$urandom(), $urandom()};
        end
        do_xfer(($urandom_range(0, 2) == 0), addr, $urandom(), snap, rd, err);
      end
    end

    // Asynchronous reset while the response is on the bus
    @(posedge clk_i); #1;
    psel_i    = 1'b1;
    penable_i = 1'b0;
    pwrite_i  = 1'b1;
    paddr_i   = 32'h00;
    pwdata_i  = 32'h1;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("resp_before_reset", pready_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("pready_async_drop", pready_o, 1'b0);
    psel_i    = 1'b0;
    penable_i = 1'b0;
    pwrite_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    do_xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, err);
    check_eq("ctrl_after_reset", rd, 32'h0);
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, err);
    check_eq("status_after_reset", rd, 32'h0);
    apb(1'b0, 32'h0C, 32'h0, 1'b0, rd, err, en);
    check_eq("hi_after_reset", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
